pc_sequencer: RTL

Registered program-counter sequencer for the pipelined SAD datapath's fetch stage. Generalises the combinational next-address adder with a parametrised width, increment and offset shift, and adds the PC register itself. It also adds stall hold, redirect priority, a configurable post-redirect bubble counter and jump-register misalignment reporting. Output `pc` feeds instruction memory; `pcPlus` feeds the IF/ID register.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_target_calc.sv | 35 +++
 rtl/pc_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: redirect control codes and FSM states.
package pc_pkg;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JR  = 2'd2;
  localparam logic [1:0] PC_JA  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target computation for branch, jump-register and jump-absolute.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic [1:0]             control,
  input  logic [WIDTH-1:0]       addIn,
  input  logic [WIDTH-1:0]       shiftIn,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-5-SHIFT:0] JAddress,
  output logic [WIDTH-1:0]       target,
  output logic                   misaligned
);

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] jr_target;
  logic [WIDTH-1:0] ja_target;

  assign br_target  = addIn + (shiftIn << SHIFT);
  assign jr_target  = {A[WIDTH-1:SHIFT], {SHIFT{1'b0}}};
  assign ja_target  = {addIn[WIDTH-1:WIDTH-4], JAddress, {SHIFT{1'b0}}};
  assign misaligned = |A[SHIFT-1:0];

  always_comb begin
    target = br_target;
    case (control)
      PC_JR:   target = jr_target;
      PC_JA:   target = ja_target;
      default: target = br_target;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with stall hold, redirect priority, post-redirect bubbles and JR alignment check.
//   state  | meaning
//   IDLE   | just out of reset; pc held at RESET_PC, fetch invalid
//   RUN    | fetching; pc advances unless stalled
//   BUBBLE | fetch invalid after a redirect; bcnt counts down to RUN
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      INC      = 4,
  parameter int unsigned      SHIFT    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      BUBBLES  = 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   stall,
  input  logic                   redirectValid,
  input  logic [1:0]             control,
  input  logic [WIDTH-1:0]       addIn,
  input  logic [WIDTH-1:0]       shiftIn,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-5-SHIFT:0] JAddress,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       pcPlus,
  output logic                   pcValid,
  output logic                   alignErr
);

  localparam logic [1:0] BCNT_LOAD = (BUBBLES == 0) ? 2'd0 : 2'(BUBBLES - 1);

  pc_state_e        state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             align_err_q, align_err_d;

  logic [WIDTH-1:0] target;
  logic             misaligned;
  logic             taken;

  pc_target_calc #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_target (
    .control    (control),
    .addIn      (addIn),
    .shiftIn    (shiftIn),
    .A          (A),
    .JAddress   (JAddress),
    .target     (target),
    .misaligned (misaligned)
  );

  assign taken = redirectValid && (control != PC_SEQ);

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    pc_d        = pc_q;
    align_err_d = 1'b0;

    if (taken) begin
      // A redirect beats every hold condition, including stall and an active bubble.
      pc_d        = target;
      align_err_d = (control == PC_JR) && misaligned;
      bcnt_d      = BCNT_LOAD;
      state_d     = (BUBBLES == 0) ? RUN : BUBBLE;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        BUBBLE: begin
          if (bcnt_q == 2'd0) begin
            state_d = RUN;
          end else begin
            bcnt_d = bcnt_q - 2'd1;
          end
        end
        RUN: begin
          if (!stall) pc_d = pc_q + WIDTH'(INC);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      bcnt_q      <= 2'd0;
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign pc       = pc_q;
  assign pcPlus   = pc_q + WIDTH'(INC);
  assign pcValid  = (state_q == RUN);
  assign alignErr = align_err_q;

endmodule
